// File: rtl/schmidl_cox_framer.sv
// Schmidl-Cox transmit framer: emits a two-identical-halves training symbol per frame,
// then the payload symbols, each preceded by its cyclic prefix.
module schmidl_cox_framer #(
    parameter int FFT_SIZE = 1024,
    parameter int CP_SIZE  = 128
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            clear,
    input  logic                            pre_wr_en,
    input  logic [$clog2(FFT_SIZE/2)-1:0]   pre_wr_addr,
    input  logic [31:0]                     pre_wr_data,
    input  logic [31:0]                     i_tdata,
    input  logic                            i_tlast,
    input  logic                            i_tvalid,
    output logic                            i_tready,
    output logic [31:0]                     o_tdata,
    output logic                            o_tlast,
    output logic                            o_tvalid,
    input  logic                            o_tready,
    output logic                            err_short
);
    localparam int HALF = FFT_SIZE / 2;
    localparam int AW_P = $clog2(HALF);
    localparam int AW_B = $clog2(FFT_SIZE);
    localparam logic [AW_B-1:0] LAST_IDX  = AW_B'(FFT_SIZE - 1);
    localparam logic [AW_B-1:0] CP_LAST   = AW_B'(CP_SIZE - 1);
    localparam logic [AW_B-1:0] B_CP_BASE = AW_B'(FFT_SIZE - CP_SIZE);
    localparam logic [AW_P-1:0] P_CP_BASE = AW_P'(HALF - CP_SIZE);

    typedef enum logic [2:0] {IDLE, PRE_CP, PRE_BODY, FILL, SYM_CP, SYM_BODY} state_t;

    logic [31:0] p_mem [HALF];
    logic [31:0] b_mem [FFT_SIZE];

    state_t          state_q, state_d;
    logic [AW_B-1:0] cnt_q, cnt_d;
    logic            end_q, end_d;
    logic            pad_q, pad_d;
    logic            i_tready_q, i_tready_d;
    logic            err_short_q, err_short_d;
    logic            rd_valid_q, rd_valid_d;
    logic            rd_last_q, rd_last_d;
    logic [31:0]     rd_data_q;
    logic            o_tvalid_q, o_tvalid_d;
    logic [31:0]     o_tdata_q, o_tdata_d;
    logic            o_tlast_q, o_tlast_d;
    logic            sk_valid_q, sk_valid_d;
    logic [31:0]     sk_data_q, sk_data_d;
    logic            sk_last_q, sk_last_d;

    logic            rd_en, rd_sel_b, b_we, p_we, pop, can_issue;
    logic [AW_P-1:0] rd_addr_p;
    logic [AW_B-1:0] rd_addr_b;
    logic [31:0]     b_wdata;
    logic [1:0]      occ;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        end_d       = end_q;
        pad_d       = pad_q;
        err_short_d = 1'b0;
        rd_en       = 1'b0;
        rd_sel_b    = 1'b0;
        rd_addr_p   = cnt_q[AW_P-1:0];
        rd_addr_b   = cnt_q;
        rd_last_d   = 1'b0;
        b_we        = 1'b0;
        b_wdata     = i_tdata;
        p_we        = 1'b0;

        // A read is issued only if the skid buffer is guaranteed room for it.
        pop       = o_tvalid_q && o_tready;
        occ       = 2'(o_tvalid_q) + 2'(sk_valid_q) + 2'(rd_valid_q);
        can_issue = (occ < 2'd2) || pop;

        case (state_q)
            IDLE: begin
                p_we = pre_wr_en;
                if (i_tvalid) begin
                    state_d = PRE_CP;
                    cnt_d   = '0;
                end
            end
            PRE_CP: begin
                rd_addr_p = P_CP_BASE + cnt_q[AW_P-1:0];
                if (can_issue) begin
                    rd_en = 1'b1;
                    cnt_d = (cnt_q == CP_LAST) ? '0 : cnt_q + 1'b1;
                    if (cnt_q == CP_LAST) state_d = PRE_BODY;
                end
            end
            PRE_BODY: begin
                if (can_issue) begin
                    rd_en = 1'b1;
                    cnt_d = (cnt_q == LAST_IDX) ? '0 : cnt_q + 1'b1;
                    if (cnt_q == LAST_IDX) state_d = FILL;
                end
            end
            FILL: begin
                if (pad_q) begin
                    b_we    = 1'b1;
                    b_wdata = '0;
                end else if (i_tvalid && i_tready_q) begin
                    b_we = 1'b1;
                    if (i_tlast) begin
                        end_d = 1'b1;
                        if (cnt_q != LAST_IDX) begin
                            err_short_d = 1'b1;
                            pad_d       = 1'b1;
                        end
                    end
                end
                if (b_we) begin
                    if (cnt_q == LAST_IDX) begin
                        state_d = SYM_CP;
                        cnt_d   = '0;
                        pad_d   = 1'b0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            SYM_CP: begin
                rd_sel_b  = 1'b1;
                rd_addr_b = B_CP_BASE + cnt_q;
                if (can_issue) begin
                    rd_en = 1'b1;
                    cnt_d = (cnt_q == CP_LAST) ? '0 : cnt_q + 1'b1;
                    if (cnt_q == CP_LAST) state_d = SYM_BODY;
                end
            end
            SYM_BODY: begin
                rd_sel_b = 1'b1;
                if (can_issue) begin
                    rd_en     = 1'b1;
                    rd_last_d = end_q && (cnt_q == LAST_IDX);
                    if (cnt_q == LAST_IDX) begin
                        cnt_d   = '0;
                        state_d = end_q ? IDLE : FILL;
                        end_d   = 1'b0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        i_tready_d = (state_d == FILL) && !pad_d;
        rd_valid_d = rd_en;

        // Two-entry skid: head feeds the port, the second entry absorbs one stalled read.
        o_tvalid_d = o_tvalid_q;
        o_tdata_d  = o_tdata_q;
        o_tlast_d  = o_tlast_q;
        sk_valid_d = sk_valid_q;
        sk_data_d  = sk_data_q;
        sk_last_d  = sk_last_q;
        if (!o_tvalid_q || pop) begin
            if (sk_valid_q) begin
                o_tvalid_d = 1'b1;
                o_tdata_d  = sk_data_q;
                o_tlast_d  = sk_last_q;
                sk_valid_d = rd_valid_q;
                if (rd_valid_q) begin
                    sk_data_d = rd_data_q;
                    sk_last_d = rd_last_q;
                end
            end else begin
                o_tvalid_d = rd_valid_q;
                if (rd_valid_q) begin
                    o_tdata_d = rd_data_q;
                    o_tlast_d = rd_last_q;
                end
            end
        end else if (rd_valid_q) begin
            sk_valid_d = 1'b1;
            sk_data_d  = rd_data_q;
            sk_last_d  = rd_last_q;
        end

        if (clear) begin
            state_d     = IDLE;
            cnt_d       = '0;
            end_d       = 1'b0;
            pad_d       = 1'b0;
            i_tready_d  = 1'b0;
            err_short_d = 1'b0;
            rd_en       = 1'b0;
            rd_valid_d  = 1'b0;
            rd_last_d   = 1'b0;
            b_we        = 1'b0;
            p_we        = 1'b0;
            o_tvalid_d  = 1'b0;
            o_tdata_d   = '0;
            o_tlast_d   = 1'b0;
            sk_valid_d  = 1'b0;
            sk_data_d   = '0;
            sk_last_d   = 1'b0;
        end
    end

    // RAMs carry no reset so that neither reset_n nor clear disturbs their contents.
    always_ff @(posedge clk) begin
        if (p_we) p_mem[pre_wr_addr] <= pre_wr_data;
        if (b_we) b_mem[cnt_q] <= b_wdata;
        if (rd_en) rd_data_q <= rd_sel_b ? b_mem[rd_addr_b] : p_mem[rd_addr_p];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            end_q       <= 1'b0;
            pad_q       <= 1'b0;
            i_tready_q  <= 1'b0;
            err_short_q <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_last_q   <= 1'b0;
            o_tvalid_q  <= 1'b0;
            o_tdata_q   <= '0;
            o_tlast_q   <= 1'b0;
            sk_valid_q  <= 1'b0;
            sk_data_q   <= '0;
            sk_last_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            end_q       <= end_d;
            pad_q       <= pad_d;
            i_tready_q  <= i_tready_d;
            err_short_q <= err_short_d;
            rd_valid_q  <= rd_valid_d;
            rd_last_q   <= rd_last_d;
            o_tvalid_q  <= o_tvalid_d;
            o_tdata_q   <= o_tdata_d;
            o_tlast_q   <= o_tlast_d;
            sk_valid_q  <= sk_valid_d;
            sk_data_q   <= sk_data_d;
            sk_last_q   <= sk_last_d;
        end
    end

    assign i_tready  = i_tready_q;
    assign err_short = err_short_q;
    assign o_tvalid  = o_tvalid_q;
    assign o_tdata   = o_tdata_q;
    assign o_tlast   = o_tlast_q;
endmodule

// File: tb/tb_schmidl_cox_framer.sv
// Scoreboard bench for schmidl_cox_framer at FFT_SIZE=16, CP_SIZE=4 with preamble 0..7.
module tb_schmidl_cox_framer;
    localparam int FFT  = 16;
    localparam int CP   = 4;
    localparam int HALF = FFT / 2;

    logic        clk, reset_n, clear, pre_wr_en;
    logic [2:0]  pre_wr_addr;
    logic [31:0] pre_wr_data, i_tdata, o_tdata;
    logic        i_tlast, i_tvalid, i_tready, o_tlast, o_tvalid, o_tready, err_short;

    int vectors = 0, miscompares = 0;
    int cyc = 0, err_cnt = 0, stall_bad = 0, first_cyc = -1;
    bit rdy_rand = 0;
    logic [32:0] exp_q[$];
    logic [32:0] obs_q[$];
    logic [31:0] pre_model [HALF];
    logic        prev_stall = 1'b0;
    logic [32:0] prev_out;

    schmidl_cox_framer #(.FFT_SIZE(FFT), .CP_SIZE(CP)) dut (
        .clk(clk), .reset_n(reset_n), .clear(clear),
        .pre_wr_en(pre_wr_en), .pre_wr_addr(pre_wr_addr), .pre_wr_data(pre_wr_data),
        .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
        .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready),
        .err_short(err_short)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1 o_tready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Output monitor: records handshakes, stall-stability breaks and err_short pulses.
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && (!o_tvalid || {o_tlast, o_tdata} !== prev_out)) stall_bad++;
            if (o_tvalid && o_tready) begin
                obs_q.push_back({o_tlast, o_tdata});
                if (first_cyc < 0) first_cyc = cyc;
            end
            prev_stall = o_tvalid && !o_tready;
            prev_out   = {o_tlast, o_tdata};
            if (err_short) err_cnt++;
        end
    end

    task automatic push_expected(input int base, input int n);
        logic [31:0] sym [FFT];
        int nsym;
        for (int k = 0; k < CP; k++) exp_q.push_back({1'b0, pre_model[HALF-CP+k]});
        for (int j = 0; j < FFT; j++) exp_q.push_back({1'b0, pre_model[j % HALF]});
        nsym = (n + FFT - 1) / FFT;
        for (int s = 0; s < nsym; s++) begin
            for (int j = 0; j < FFT; j++) sym[j] = (s*FFT + j < n) ? 32'(base + s*FFT + j) : 32'd0;
            for (int k = 0; k < CP; k++) exp_q.push_back({1'b0, sym[FFT-CP+k]});
            for (int j = 0; j < FFT; j++) exp_q.push_back({(s == nsym-1) && (j == FFT-1), sym[j]});
        end
    endtask

    task automatic drive_frame(input int base, input int n, input bit last_at_end,
                               input int poke_idx, output int start_cyc, output bit ok);
        int i = 0;
        int guard = 0;
        @(posedge clk); #1;
        start_cyc = cyc;
        i_tvalid = 1'b1;
        i_tdata  = 32'(base);
        i_tlast  = last_at_end && (n == 1);
        while (i < n && guard < 6000) begin
            @(negedge clk);
            guard++;
            if (i_tready) begin
                if (i == poke_idx) begin
                    pre_wr_en = 1'b1; pre_wr_addr = 3'd0; pre_wr_data = 32'hFFFF_FFFF;
                end
                @(posedge clk); #1;
                pre_wr_en = 1'b0;
                i++;
                i_tdata = 32'(base + i);
                i_tlast = last_at_end && (i == n-1);
            end
        end
        i_tvalid = 1'b0;
        i_tlast  = 1'b0;
        ok = (i == n);
    endtask

    task automatic wait_outputs(input int n, output bit ok);
        int guard = 0;
        while (obs_q.size() < n && guard < 6000) begin
            @(negedge clk);
            guard++;
        end
        repeat (8) @(negedge clk);
        ok = (obs_q.size() == n);
    endtask

    task automatic test_reset;
        reset_n = 1'b0; clear = 1'b0; pre_wr_en = 1'b0; pre_wr_addr = '0; pre_wr_data = '0;
        i_tdata = '0; i_tlast = 1'b0; i_tvalid = 1'b0;
        repeat (3) @(negedge clk);
        vectors += 5;
        if (o_tvalid !== 1'b0)   begin miscompares++; $display("[TB] FAIL reset_o_tvalid: got %b want 0", o_tvalid); end
        if (i_tready !== 1'b0)   begin miscompares++; $display("[TB] FAIL reset_i_tready: got %b want 0", i_tready); end
        if (o_tlast !== 1'b0)    begin miscompares++; $display("[TB] FAIL reset_o_tlast: got %b want 0", o_tlast); end
        if (o_tdata !== 32'd0)   begin miscompares++; $display("[TB] FAIL reset_o_tdata: got %h want 0", o_tdata); end
        if (err_short !== 1'b0)  begin miscompares++; $display("[TB] FAIL reset_err_short: got %b want 0", err_short); end
        reset_n = 1'b1;
        for (int a = 0; a < HALF; a++) begin
            @(posedge clk); #1;
            pre_wr_en = 1'b1; pre_wr_addr = 3'(a); pre_wr_data = 32'(a);
            pre_model[a] = 32'(a);
        end
        @(posedge clk); #1;
        pre_wr_en = 1'b0;
    endtask

    task automatic test_nominal;
        int c0; bit ok; logic [32:0] e, a;
        obs_q.delete(); exp_q.delete(); err_cnt = 0; first_cyc = -1;
        push_expected(100, 32);
        drive_frame(100, 32, 1'b1, -1, c0, ok);
        vectors++;
        if (!ok) begin miscompares++; $display("[TB] FAIL nominal_input: frame not accepted"); end
        wait_outputs(exp_q.size(), ok);
        vectors += 3;
        if (!ok) begin miscompares++; $display("[TB] FAIL nominal_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        if (first_cyc < 0 || first_cyc - c0 > 4) begin
            miscompares++; $display("[TB] FAIL nominal_latency: got %0d cycles want <=4", first_cyc - c0);
        end
        if (err_cnt !== 0) begin miscompares++; $display("[TB] FAIL nominal_err_short: got %0d want 0", err_cnt); end
        for (int k = 0; exp_q.size() > 0; k++) begin
            e = exp_q.pop_front();
            a = (obs_q.size() > 0) ? obs_q.pop_front() : 33'bx;
            vectors++;
            if (a !== e) begin miscompares++; $display("[TB] FAIL nominal[%0d]: got last=%b data=%h want last=%b data=%h", k, a[32], a[31:0], e[32], e[31:0]); end
        end
    endtask

    task automatic test_backpressure;
        int c0; bit ok; logic [32:0] e, a;
        obs_q.delete(); exp_q.delete(); stall_bad = 0;
        rdy_rand = 1'b1;
        push_expected(100, 32);
        drive_frame(100, 32, 1'b1, -1, c0, ok);
        vectors++;
        if (!ok) begin miscompares++; $display("[TB] FAIL bp_input: frame not accepted"); end
        wait_outputs(exp_q.size(), ok);
        rdy_rand = 1'b0;
        vectors += 2;
        if (!ok) begin miscompares++; $display("[TB] FAIL bp_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        if (stall_bad !== 0) begin miscompares++; $display("[TB] FAIL bp_stall_stable: got %0d violations want 0", stall_bad); end
        for (int k = 0; exp_q.size() > 0; k++) begin
            e = exp_q.pop_front();
            a = (obs_q.size() > 0) ? obs_q.pop_front() : 33'bx;
            vectors++;
            if (a !== e) begin miscompares++; $display("[TB] FAIL bp[%0d]: got last=%b data=%h want last=%b data=%h", k, a[32], a[31:0], e[32], e[31:0]); end
        end
    endtask

    task automatic test_short_symbol;
        int c0; bit ok; logic [32:0] e, a;
        obs_q.delete(); exp_q.delete(); err_cnt = 0;
        push_expected(200, 10);
        drive_frame(200, 10, 1'b1, -1, c0, ok);
        wait_outputs(exp_q.size(), ok);
        vectors += 2;
        if (!ok) begin miscompares++; $display("[TB] FAIL short_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        if (err_cnt !== 1) begin miscompares++; $display("[TB] FAIL short_err_pulses: got %0d want 1", err_cnt); end
        for (int k = 0; exp_q.size() > 0; k++) begin
            e = exp_q.pop_front();
            a = (obs_q.size() > 0) ? obs_q.pop_front() : 33'bx;
            vectors++;
            if (a !== e) begin miscompares++; $display("[TB] FAIL short[%0d]: got last=%b data=%h want last=%b data=%h", k, a[32], a[31:0], e[32], e[31:0]); end
        end
    endtask

    task automatic test_prewr_guard;
        int c0; bit ok; logic [32:0] e, a;
        obs_q.delete(); exp_q.delete();
        push_expected(800, 16);
        push_expected(900, 4);
        drive_frame(800, 16, 1'b1, 5, c0, ok);
        drive_frame(900, 4, 1'b1, -1, c0, ok);
        wait_outputs(exp_q.size(), ok);
        vectors++;
        if (!ok) begin miscompares++; $display("[TB] FAIL guard_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int k = 0; exp_q.size() > 0; k++) begin
            e = exp_q.pop_front();
            a = (obs_q.size() > 0) ? obs_q.pop_front() : 33'bx;
            vectors++;
            if (a !== e) begin miscompares++; $display("[TB] FAIL guard[%0d]: got last=%b data=%h want last=%b data=%h", k, a[32], a[31:0], e[32], e[31:0]); end
        end
    endtask

    task automatic test_reset_midframe;
        int c0, guard; bit ok; logic [32:0] e, a;
        obs_q.delete(); exp_q.delete();
        drive_frame(400, 16, 1'b0, -1, c0, ok);
        guard = 0;
        while (obs_q.size() < 26 && guard < 2000) begin @(negedge clk); guard++; end
        vectors++;
        if (obs_q.size() < 26) begin miscompares++; $display("[TB] FAIL rst_mid_reach: got %0d outputs want 26", obs_q.size()); end
        #2 reset_n = 1'b0;
        #1;
        vectors += 2;
        if (o_tvalid !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_mid_o_tvalid: got %b want 0", o_tvalid); end
        if (i_tready !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_mid_i_tready: got %b want 0", i_tready); end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        obs_q.delete(); exp_q.delete();
        push_expected(500, 16);
        drive_frame(500, 16, 1'b1, -1, c0, ok);
        wait_outputs(exp_q.size(), ok);
        vectors++;
        if (!ok) begin miscompares++; $display("[TB] FAIL rst_mid_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int k = 0; exp_q.size() > 0; k++) begin
            e = exp_q.pop_front();
            a = (obs_q.size() > 0) ? obs_q.pop_front() : 33'bx;
            vectors++;
            if (a !== e) begin miscompares++; $display("[TB] FAIL rst_mid[%0d]: got last=%b data=%h want last=%b data=%h", k, a[32], a[31:0], e[32], e[31:0]); end
        end
    endtask

    task automatic test_clear_midframe;
        int c0, guard; bit ok; logic [32:0] e, a;
        obs_q.delete(); exp_q.delete();
        @(posedge clk); #1;
        i_tvalid = 1'b1; i_tdata = 32'd600;
        @(posedge clk); #1;
        i_tvalid = 1'b0;
        guard = 0;
        while (obs_q.size() < 6 && guard < 200) begin @(negedge clk); guard++; end
        @(posedge clk); #1;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        vectors += 2;
        if (o_tvalid !== 1'b0) begin miscompares++; $display("[TB] FAIL clear_o_tvalid: got %b want 0", o_tvalid); end
        if (i_tready !== 1'b0) begin miscompares++; $display("[TB] FAIL clear_i_tready: got %b want 0", i_tready); end
        obs_q.delete();
        repeat (6) @(negedge clk);
        vectors++;
        if (obs_q.size() !== 0) begin miscompares++; $display("[TB] FAIL clear_idle: got %0d outputs want 0", obs_q.size()); end
        obs_q.delete();
        push_expected(700, 16);
        drive_frame(700, 16, 1'b1, -1, c0, ok);
        wait_outputs(exp_q.size(), ok);
        vectors++;
        if (!ok) begin miscompares++; $display("[TB] FAIL clear_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int k = 0; exp_q.size() > 0; k++) begin
            e = exp_q.pop_front();
            a = (obs_q.size() > 0) ? obs_q.pop_front() : 33'bx;
            vectors++;
            if (a !== e) begin miscompares++; $display("[TB] FAIL clear[%0d]: got last=%b data=%h want last=%b data=%h", k, a[32], a[31:0], e[32], e[31:0]); end
        end
    endtask

    initial begin
        o_tready = 1'b1;
        test_reset();
        test_nominal();
        test_backpressure();
        test_short_symbol();
        test_prewr_guard();
        test_reset_midframe();
        test_clear_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
